// File: rtl/ifetch_prefetch_pkg.sv
// Shared fetch-unit types: FSM state encodings used by ifetch_prefetch.
// Kept beside the ALU defines so the core shares one encoding source.
package ifetch_prefetch_pkg;

  localparam int IF_ST_W = 2;

  typedef enum logic [IF_ST_W-1:0] {
    IF_ST_IDLE = 2'd0,
    IF_ST_REQ  = 2'd1,
    IF_ST_WAIT = 2'd2,
    IF_ST_DROP = 2'd3
  } ifState_e;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetch-unit bundles: memory request/response bus and the decoder-facing
// instruction stream, each with master/slave views.
interface ifetch_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

interface ifetch_inst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/ifetch_prefetch_fifo.sv
// Prefetch queue: power-of-two synchronous FIFO with flush.
// Flush beats push and pop; the head reads as zero when empty.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !flush && !full;
  assign doPop  = pop && !flush && !empty;

  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a
// prefetch queue, with redirect flush and halt.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  ifetch_mem_if.master      mem,
  ifetch_inst_if.master     inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);

  ifState_e          state;
  ifState_e          stateNext;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] fetchPcNext;
  logic [ADDR_W-1:0] reqPc;
  logic [ADDR_W-1:0] reqPcNext;
  logic [ADDR_W-1:0] reqAddr;
  logic [ADDR_W-1:0] reqAddrNext;
  logic              reqValid;
  logic              reqValidNext;
  logic              stale;
  logic              staleNext;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    cntAfter;
  logic              roomAfter;
  logic              accept;
  logic [ADDR_W-1:0] redirAligned;
  logic [ENT_W-1:0]  headEnt;

  assign accept       = reqValid && mem.mem_req_ready;
  assign redirAligned = redirect_pc & ~STEP_MASK;
  assign pop          = !empty && inst.inst_ready;
  assign cntAfter     = {1'b0, count} + (CNT_W+1)'(1)
                      - (CNT_W+1)'(pop);
  assign roomAfter    = cntAfter < (CNT_W+1)'(DEPTH);

  assign mem.mem_req_valid = reqValid;
  assign mem.mem_req_addr  = reqAddr;
  assign inst.inst_valid   = !empty;
  assign inst.inst_data    = headEnt[ENT_W-1:ADDR_W];
  assign inst.inst_pc      = headEnt[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IF_ST_IDLE;
      fetchPc  <= RESET_PC;
      reqPc    <= '0;
      reqAddr  <= RESET_PC;
      reqValid <= 1'b0;
      stale    <= 1'b0;
    end else begin
      state    <= stateNext;
      fetchPc  <= fetchPcNext;
      reqPc    <= reqPcNext;
      reqAddr  <= reqAddrNext;
      reqValid <= reqValidNext;
      stale    <= staleNext;
    end
  end

  always_comb begin
    stateNext    = state;
    fetchPcNext  = fetchPc;
    reqPcNext    = reqPc;
    reqAddrNext  = reqAddr;
    reqValidNext = reqValid;
    staleNext    = stale;
    push         = 1'b0;
    unique case (state)
      IF_ST_IDLE: begin
        if (!halt && !redirect_valid && !full) begin
          stateNext    = IF_ST_REQ;
          reqValidNext = 1'b1;
          reqAddrNext  = fetchPc;
        end
      end
      IF_ST_REQ: begin
        if (accept) begin
          reqValidNext = 1'b0;
          reqPcNext    = reqAddr;
          staleNext    = 1'b0;
          if (stale || redirect_valid) begin
            stateNext = IF_ST_DROP;
          end else begin
            stateNext   = IF_ST_WAIT;
            fetchPcNext = fetchPc + STEP;
          end
        end else if (redirect_valid) begin
          staleNext = 1'b1;
        end
      end
      IF_ST_WAIT: begin
        if (redirect_valid) begin
          stateNext = mem.mem_rsp_valid ? IF_ST_IDLE
                                        : IF_ST_DROP;
        end else if (mem.mem_rsp_valid) begin
          push = 1'b1;
          if (!halt && roomAfter) begin
            stateNext    = IF_ST_REQ;
            reqValidNext = 1'b1;
            reqAddrNext  = fetchPc;
          end else begin
            stateNext = IF_ST_IDLE;
          end
        end
      end
      IF_ST_DROP: begin
        if (mem.mem_rsp_valid) stateNext = IF_ST_IDLE;
      end
      default: stateNext = IF_ST_IDLE;
    endcase
    // A redirect always wins the next fetch address.
    if (redirect_valid) fetchPcNext = redirAligned;
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .pushData ({mem.mem_rsp_data, reqPc}),
    .pop      (pop),
    .popData  (headEnt),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: latency-programmable memory, stream-level
// fetch model checked every cycle, plus directed literal checks.
module tb_ifetch_prefetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  logic redirectValid;
  logic [31:0] redirectPc;
  logic halt;
  logic memReady;
  logic instReady;
  int   rspLat;

  always #5 clk = ~clk;

  ifetch_mem_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memBus();
  ifetch_inst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) instBus();

  assign memBus.mem_req_ready = memReady;
  assign instBus.inst_ready   = instReady;

  ifetch_prefetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem            (memBus),
    .inst           (instBus),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .halt           (halt)
  );

  // Memory: answers each accepted request rspLat cycles later
  logic busy;
  int   cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      memBus.mem_rsp_valid <= 1'b0;
      memBus.mem_rsp_data  <= '0;
      busy <= 1'b0;
      cnt  <= 0;
    end else begin
      memBus.mem_rsp_valid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          memBus.mem_rsp_valid <= 1'b1;
          busy <= 1'b0;
        end else cnt <= cnt - 1;
      end
      if (memBus.mem_req_valid && memReady) begin
        memBus.mem_rsp_data <= memBus.mem_req_addr ^ KEY;
        if (rspLat <= 1) memBus.mem_rsp_valid <= 1'b1;
        else begin
          busy <= 1'b1;
          cnt  <= rspLat - 1;
        end
      end
    end
  end

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  int reqCount = 0;
  int popCount = 0;
  int epoch = 0;
  int issueEpoch = -1;
  logic [31:0] lastAccAddr;
  logic [31:0] expPc;
  logic [31:0] expReq;
  logic [31:0] stallAddr;
  bit wasStall;
  bit afterRedir;
  logic [31:0] popLog[$];
  int popCyc[$];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (!ok) begin
      nFail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream model: decoder must see consecutive PCs from the last
  // reset/redirect target, data = pc ^ KEY; fresh requests likewise.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        expPc = RESET_PC;
        expReq = RESET_PC;
        epoch++;
        wasStall = 0;
        afterRedir = 0;
      end else begin
        if (wasStall) begin
          check(memBus.mem_req_valid === 1'b1, "reqHoldValid",
                {31'b0, memBus.mem_req_valid}, 32'd1);
          check(memBus.mem_req_addr === stallAddr, "reqHoldAddr",
                memBus.mem_req_addr, stallAddr);
        end
        if (memBus.mem_req_valid && !wasStall) issueEpoch = epoch;
        if (memBus.mem_req_valid && memReady) begin
          reqCount++;
          lastAccAddr = memBus.mem_req_addr;
          if (issueEpoch == epoch) begin
            check(memBus.mem_req_addr === expReq, "reqAddr",
                  memBus.mem_req_addr, expReq);
            expReq += 32'd4;
          end
        end
        wasStall = memBus.mem_req_valid && !memReady;
        stallAddr = memBus.mem_req_addr;
        if (afterRedir)
          check(instBus.inst_valid === 1'b0, "flushValid",
                {31'b0, instBus.inst_valid}, 32'd0);
        if (redirectValid) begin
          epoch++;
          expReq = redirectPc & ~32'h3;
          expPc = redirectPc & ~32'h3;
          afterRedir = 1;
        end else begin
          afterRedir = 0;
          if (instBus.inst_valid && instReady) begin
            check(instBus.inst_pc === expPc, "popPc",
                  instBus.inst_pc, expPc);
            check(instBus.inst_data === (expPc ^ KEY), "popData",
                  instBus.inst_data, expPc ^ KEY);
            popLog.push_back(instBus.inst_pc);
            popCyc.push_back(cyc);
            popCount++;
            expPc += 32'd4;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic waitReq(input int target, input string name);
    int n = 0;
    while (reqCount < target && n < 300) begin
      step();
      n++;
    end
    check(reqCount >= target, name, 32'(reqCount), 32'(target));
  endtask

  task automatic waitPop(input int target, input string name);
    int n = 0;
    while (popCount < target && n < 300) begin
      step();
      n++;
    end
    check(popCount >= target, name, 32'(popCount), 32'(target));
  endtask

  logic [31:0] seq0 [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] seqW [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

  initial begin
    int p0;
    int r0;
    int n;
    reset = 1'b1;
    redirectValid = 1'b0;
    redirectPc = '0;
    halt = 1'b0;
    memReady = 1'b1;
    instReady = 1'b1;
    rspLat = 1;
    fork
      monitor();
    join_none

    // Reset values
    step();
    check(memBus.mem_req_valid === 1'b0, "rstReqValid",
          {31'b0, memBus.mem_req_valid}, 32'd0);
    check(memBus.mem_req_addr === RESET_PC, "rstReqAddr",
          memBus.mem_req_addr, RESET_PC);
    check(instBus.inst_valid === 1'b0, "rstInstValid",
          {31'b0, instBus.inst_valid}, 32'd0);
    check(instBus.inst_data === 32'h0, "rstInstData",
          instBus.inst_data, 32'h0);
    check(instBus.inst_pc === 32'h0, "rstInstPc", instBus.inst_pc, 32'h0);
    step();
    reset = 1'b0;

    // 1: streaming, one instruction per 2 cycles
    p0 = popCount;
    waitPop(p0 + 4, "t1Timeout");
    for (int i = 0; i < 4; i++)
      check(popLog[p0+i] === seq0[i], "t1Pc", popLog[p0+i], seq0[i]);
    for (int i = 1; i < 4; i++)
      check(popCyc[p0+i] - popCyc[p0+i-1] == 2, "t1Rate",
            32'(popCyc[p0+i] - popCyc[p0+i-1]), 32'd2);

    // 2: queue fills, fetch stops, drains in order, resumes at 16
    instReady = 1'b0;
    doReset();
    r0 = reqCount;
    p0 = popCount;
    repeat (30) step();
    check(reqCount - r0 == 4, "t2Reqs", 32'(reqCount - r0), 32'd4);
    check(memBus.mem_req_valid === 1'b0, "t2Idle",
          {31'b0, memBus.mem_req_valid}, 32'd0);
    check(instBus.inst_pc === 32'h0, "t2Head", instBus.inst_pc, 32'h0);
    instReady = 1'b1;
    waitReq(r0 + 5, "t2ReqTimeout");
    check(lastAccAddr === 32'h10, "t2Resume", lastAccAddr, 32'h10);
    waitPop(p0 + 4, "t2PopTimeout");
    for (int i = 0; i < 4; i++)
      check(popLog[p0+i] === seq0[i], "t2Order", popLog[p0+i], seq0[i]);

    // 3: request held while memory stalls
    memReady = 1'b0;
    instReady = 1'b0;
    doReset();
    r0 = reqCount;
    n = 0;
    while (!memBus.mem_req_valid && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check(memBus.mem_req_valid === 1'b1 && memBus.mem_req_addr === 32'h0,
            "t3Hold", memBus.mem_req_addr, 32'h0);
      if (i < 4) step();
    end
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    repeat (6) step();
    check(reqCount - r0 == 1, "t3OneAccept", 32'(reqCount - r0), 32'd1);
    check(instBus.inst_valid === 1'b1 && instBus.inst_pc === 32'h0,
          "t3Push", instBus.inst_pc, 32'h0);
    instReady = 1'b1;
    step();
    instReady = 1'b0;
    check(instBus.inst_valid === 1'b0, "t3OnePush",
          {31'b0, instBus.inst_valid}, 32'd0);

    // 4: redirect while waiting on a slow response
    memReady = 1'b1;
    instReady = 1'b1;
    rspLat = 3;
    doReset();
    r0 = reqCount;
    waitReq(r0 + 1, "t4AccTimeout");
    redirectValid = 1'b1;
    redirectPc = 32'h103;
    step();
    redirectValid = 1'b0;
    check(instBus.inst_valid === 1'b0, "t4Flush",
          {31'b0, instBus.inst_valid}, 32'd0);
    p0 = popCount;
    waitReq(r0 + 2, "t4ReqTimeout");
    check(lastAccAddr === 32'h100, "t4NewAddr", lastAccAddr, 32'h100);
    waitPop(p0 + 1, "t4PopTimeout");
    check(popLog[p0] === 32'h100, "t4FirstPc", popLog[p0], 32'h100);

    // 5: redirect + response + pop in one cycle, 2 queued
    rspLat = 1;
    instReady = 1'b0;
    doReset();
    n = 0;
    while (n < 3) begin
      step();
      if (memBus.mem_rsp_valid) n++;
      if (cyc > 2000) break;
    end
    check(instBus.inst_valid === 1'b1, "t5Queued",
          {31'b0, instBus.inst_valid}, 32'd1);
    redirectValid = 1'b1;
    redirectPc = 32'h200;
    instReady = 1'b1;
    p0 = popCount;
    r0 = reqCount;
    step();
    redirectValid = 1'b0;
    check(instBus.inst_valid === 1'b0, "t5Empty",
          {31'b0, instBus.inst_valid}, 32'd0);
    check(popCount == p0, "t5NoPop", 32'(popCount), 32'(p0));
    waitReq(r0 + 1, "t5ReqTimeout");
    check(lastAccAddr === 32'h200, "t5NewAddr", lastAccAddr, 32'h200);
    waitPop(p0 + 1, "t5PopTimeout");
    check(popLog[p0] === 32'h200, "t5FirstPc", popLog[p0], 32'h200);

    // 6: halt during WAIT, then asynchronous reset mid-REQ
    rspLat = 3;
    doReset();
    r0 = reqCount;
    waitReq(r0 + 1, "t6AccTimeout");
    halt = 1'b1;
    p0 = popCount;
    repeat (12) step();
    check(reqCount - r0 == 1, "t6NoReq", 32'(reqCount - r0), 32'd1);
    check(memBus.mem_req_valid === 1'b0, "t6Halted",
          {31'b0, memBus.mem_req_valid}, 32'd0);
    check(popCount - p0 == 1, "t6Queued", 32'(popCount - p0), 32'd1);
    check(popLog[p0] === 32'h0, "t6Pc", popLog[p0], 32'h0);
    instReady = 1'b0;
    halt = 1'b0;
    rspLat = 1;
    n = 0;
    while (!(instBus.inst_valid && memBus.mem_req_valid) && n < 50) begin
      step();
      n++;
    end
    memReady = 1'b0;
    step();
    check(memBus.mem_req_valid === 1'b1 && instBus.inst_valid === 1'b1,
          "t6Busy", {31'b0, memBus.mem_req_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check(memBus.mem_req_valid === 1'b0, "t6AsyncReq",
          {31'b0, memBus.mem_req_valid}, 32'd0);
    check(instBus.inst_valid === 1'b0, "t6AsyncInst",
          {31'b0, instBus.inst_valid}, 32'd0);
    step();
    step();
    reset = 1'b0;
    memReady = 1'b1;
    r0 = reqCount;
    waitReq(r0 + 1, "t6RstTimeout");
    check(lastAccAddr === RESET_PC, "t6RstAddr", lastAccAddr, RESET_PC);

    // 7: redirect to unaligned top of address space, PC wraps
    instReady = 1'b1;
    doReset();
    redirectValid = 1'b1;
    redirectPc = 32'hFFFF_FFF9;
    step();
    redirectValid = 1'b0;
    p0 = popCount;
    waitPop(p0 + 4, "t7Timeout");
    for (int i = 0; i < 4; i++)
      check(popLog[p0+i] === seqW[i], "t7Wrap", popLog[p0+i], seqW[i]);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Parametrised instruction fetch unit for the next-generation core. It replaces the fixed PC unit and combinational ROM lookup with a variable-latency memory request/response interface and a DEPTH-entry prefetch queue. The queue feeds the decoder through a valid/ready handshake. Jumps and branches are applied through a redirect port that flushes stale instructions.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches (power of two)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
mem_req_valid  out  1  fetch request valid (registered)
mem_req_ready  in  1  memory accepts request this cycle
mem_req_addr  out  ADDR_W  fetch address, held stable while mem_req_valid && !mem_req_ready
mem_rsp_valid  in  1  response data valid (at most one per accepted request, >=1 cycle after acceptance)
mem_rsp_data  in  DATA_W  instruction word
inst_valid  out  1  queue head valid
inst_ready  in  1  decoder consumes head
inst_data  out  DATA_W  head instruction
inst_pc  out  ADDR_W  address of head instruction
redirect_valid  in  1  jump taken; flush and refetch
redirect_pc  in  ADDR_W  new fetch address
halt  in  1  stop issuing new requests

Behaviour:
- Reset values: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_pc=RESET_PC, queue count=0, state=IDLE.
- Reset mid-transaction abandons any outstanding request. The memory side must be reset by the same signal.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: mem_req_valid high.
  - WAIT: request accepted, awaiting response.
  - DROP: accepted request is stale; its response will be discarded.
- IDLE->REQ when !halt && !redirect_valid && count<DEPTH. Set mem_req_addr=fetch_pc.
- REQ->WAIT on mem_req_ready. Latch req_pc=mem_req_addr and set fetch_pc+=PC_STEP (wraps modulo 2^ADDR_W).
- REQ with redirect_valid: the request stays asserted, unchanged, until accepted, then goes to DROP (stale flag set).
- WAIT on mem_rsp_valid: push {mem_rsp_data, req_pc}. Next state is REQ if !halt && count_after_push<DEPTH, else IDLE. Back-to-back with zero-wait memory gives one instruction per 2 cycles.
- WAIT with redirect_valid (with or without mem_rsp_valid): no push; go to DROP, or to IDLE if mem_rsp_valid is high the same cycle.
- DROP on mem_rsp_valid: discard the response, go to IDLE.
- Slot reservation: a request issues only when count<DEPTH, so a push never meets a full queue.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- Queue head appears on inst_* in the cycle after the push edge (registered FIFO output), so rsp->inst_valid latency is 1 cycle.
- Pop happens when inst_valid && inst_ready.
- Redirect (highest priority):
  - Next cycle: count=0 and inst_valid=0.
  - fetch_pc=redirect_pc with low log2(PC_STEP) bits cleared.
  - A push or pop in the same cycle is cancelled.
  - The first new request issues no earlier than the cycle after the redirect.
- halt: blocks IDLE->REQ and WAIT->REQ only. An outstanding request completes and is queued. The queue keeps draining.
- Wrap: fetch_pc at 2^ADDR_W-PC_STEP increments to 0. Queue pointers wrap modulo DEPTH.

Decomposition:
- Shared defines header, alongside the existing ALU defines: IF_ST_IDLE/REQ/WAIT/DROP state encodings (2-bit).
- One sub-module, prefetch_fifo: synchronous FIFO, parameters DEPTH and WIDTH=DATA_W+ADDR_W, with push/pop/flush ports and count/full/empty outputs.
- Flush has priority over push/pop inside prefetch_fifo.
- The top level holds the FSM, fetch_pc, req_pc and redirect logic.

Test Plan:
1. Reset release, mem ready=1, rsp 1 cycle after accept, data=addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching data, one valid instruction every 2 cycles.
2. inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid stays 0. Set inst_ready=1 -> 4 pops in order, fetching resumes at addr 16.
3. mem_req_ready held 0 for 5 cycles -> mem_req_valid=1 and mem_req_addr=0 stable for all 5 cycles. Accept on cycle 6 -> exactly one push.
4. Redirect to 32'h103 while in WAIT (rsp arrives 3 cycles later) -> that response is discarded, next request addr=32'h100, inst_valid=0 in the cycle after the redirect, first inst_pc=32'h100.
5. Redirect in the same cycle as mem_rsp_valid and a pop with 2 entries queued -> count=0 next cycle, no push, next request addr=redirect target.
6. halt=1 during WAIT -> response queued, no further mem_req_valid. Assert reset mid-REQ -> mem_req_valid=0 and inst_valid=0 immediately (asynchronous), first request addr=RESET_PC after release.
